// File: rtl/axis_trigger_detector.sv
// Level/edge trigger detector on a 2x16-bit AXI-Stream sample pipe.
// Samples pass through with one cycle of latency; trg_flag marks the output beat that fired.
module axis_trigger_detector #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        areset,

  input  logic                        en_flag,
  input  logic                        ch_flag,
  input  logic                        pol_flag,
  input  logic [15:0]                 lvl_data,
  input  logic [15:0]                 hys_data,
  input  logic [CNTR_WIDTH-1:0]       hld_data,

  output logic                        trg_flag,
  output logic [CNTR_WIDTH-1:0]       sts_data,

  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,

  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid
);

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  state_t                        state_reg, state_next;
  logic [CNTR_WIDTH-1:0]         hld_cnt_reg, hld_cnt_next;
  logic [CNTR_WIDTH-1:0]         trg_cnt_reg, trg_cnt_next;
  logic                          trg_reg, trg_next;
  logic [AXIS_TDATA_WIDTH-1:0]   tdata_reg;
  logic                          tvalid_reg;

  logic [15:0]                   sample;
  logic signed [16:0]            x_ext, lvl_ext, hys_ext;
  logic signed [17:0]            arm_lo, arm_hi;
  logic                          arm_hit, fire_hit;

  assign sample  = ch_flag ? s_axis_tdata[31:16] : s_axis_tdata[15:0];
  assign x_ext   = {sample[15], sample};
  assign lvl_ext = {lvl_data[15], lvl_data};
  assign hys_ext = {1'b0, hys_data};

  // One guard bit on the thresholds keeps lvl +/- hys exact for every level/hysteresis pair.
  assign arm_lo = 18'(lvl_ext) - 18'(hys_ext);
  assign arm_hi = 18'(lvl_ext) + 18'(hys_ext);

  assign arm_hit  = pol_flag ? (18'(x_ext) >= arm_hi) : (18'(x_ext) <= arm_lo);
  assign fire_hit = pol_flag ? (x_ext <= lvl_ext)     : (x_ext >= lvl_ext);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg   <= DISARMED;
      hld_cnt_reg <= '0;
      trg_cnt_reg <= '0;
      trg_reg     <= 1'b0;
      tdata_reg   <= '0;
      tvalid_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hld_cnt_reg <= hld_cnt_next;
      trg_cnt_reg <= trg_cnt_next;
      trg_reg     <= trg_next;
      tdata_reg   <= s_axis_tdata;
      tvalid_reg  <= s_axis_tvalid;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hld_cnt_next = hld_cnt_reg;
    trg_cnt_next = trg_cnt_reg;
    trg_next     = 1'b0;

    // Disable wins over everything and does not wait for a valid beat.
    if (!en_flag) begin
      state_next = DISARMED;
    end else begin
      case (state_reg)
        DISARMED: state_next = ARMING;
        ARMING: begin
          if (s_axis_tvalid && arm_hit) begin
            state_next = ARMED;
          end
        end
        ARMED: begin
          if (s_axis_tvalid && fire_hit) begin
            state_next   = HOLDOFF;
            hld_cnt_next = '0;
            trg_next     = 1'b1;
            trg_cnt_next = trg_cnt_reg + CNT_ONE;
          end
        end
        HOLDOFF: begin
          if (s_axis_tvalid) begin
            if (hld_cnt_reg == hld_data) begin
              state_next = ARMING;
            end else begin
              hld_cnt_next = hld_cnt_reg + CNT_ONE;
            end
          end
        end
        default: state_next = DISARMED;
      endcase
    end
  end

  assign trg_flag      = trg_reg;
  assign sts_data      = trg_cnt_reg;
  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;

endmodule

// File: tb/tb_axis_trigger_detector.sv
// Directed bench for axis_trigger_detector: integer-level reference model checked every cycle,
// plus literal expectations per scenario.
module tb_axis_trigger_detector;
  localparam int DW = 32;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          en_flag = 1'b0;
  logic          ch_flag = 1'b0;
  logic          pol_flag = 1'b0;
  logic [15:0]   lvl_data = '0;
  logic [15:0]   hys_data = '0;
  logic [CW-1:0] hld_data = '0;
  logic          trg_flag;
  logic [CW-1:0] sts_data;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;

  axis_trigger_detector #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset),
    .en_flag(en_flag), .ch_flag(ch_flag), .pol_flag(pol_flag),
    .lvl_data(lvl_data), .hys_data(hys_data), .hld_data(hld_data),
    .trg_flag(trg_flag), .sts_data(sts_data),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the selected channel, phase 0=off,
  // 1=waiting for arm, 2=waiting for fire, 3=holdoff with a beat countdown.
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_trg;
  logic [CW-1:0] exp_sts;
  bit            model_ready = 0;

  initial begin : model
    int m_phase;
    int m_left;
    int x, lvl, hys;
    bit fire_now;
    m_phase = 0;
    m_left  = 0;
    forever begin
      @(posedge aclk);
      fire_now = 0;
      x   = ch_flag ? int'($signed(s_axis_tdata[31:16])) : int'($signed(s_axis_tdata[15:0]));
      lvl = int'($signed(lvl_data));
      hys = int'(hys_data);
      if (areset) begin
        m_phase = 0; m_left = 0;
        exp_data = '0; exp_valid = 1'b0; exp_trg = 1'b0; exp_sts = '0;
      end else begin
        exp_data  = s_axis_tdata;
        exp_valid = s_axis_tvalid;
        if (!en_flag) m_phase = 0;
        else if (m_phase == 0) m_phase = 1;
        else if (s_axis_tvalid) begin
          case (m_phase)
            1: if (pol_flag ? (x >= lvl + hys) : (x <= lvl - hys)) m_phase = 2;
            2: if (pol_flag ? (x <= lvl) : (x >= lvl)) begin
                 fire_now = 1; m_phase = 3; m_left = int'(hld_data);
               end
            3: if (m_left == 0) m_phase = 1; else m_left--;
            default: ;
          endcase
        end
        exp_trg = fire_now;
        if (fire_now) exp_sts = exp_sts + 32'd1;
      end
      model_ready = 1;
    end
  end

  // Observation log of DUT triggers, used by the literal checks.
  int trig_ch0[$];
  int trig_ch1[$];
  int trig_idx[$];

  initial begin : compare
    int out_idx;
    logic trg_prev;
    out_idx  = 0;
    trg_prev = 1'b0;
    forever begin
      @(negedge aclk);
      if (model_ready) begin
        check("m_axis_tdata", m_axis_tdata, exp_data);
        check("m_axis_tvalid", m_axis_tvalid, exp_valid);
        check("trg_flag", trg_flag, exp_trg);
        check("sts_data", sts_data, exp_sts);
        check("s_axis_tready", s_axis_tready, 1);
        check("trg_without_valid", trg_flag & ~m_axis_tvalid, 0);
        check("trg_back_to_back", trg_flag & trg_prev, 0);
      end
      if (m_axis_tvalid === 1'b1) out_idx++;
      if (trg_flag === 1'b1) begin
        trig_ch0.push_back(int'($signed(m_axis_tdata[15:0])));
        trig_ch1.push_back(int'($signed(m_axis_tdata[31:16])));
        trig_idx.push_back(out_idx);
      end
      trg_prev = trg_flag;
    end
  end

  task automatic beat(input int c0, input int c1, input bit v);
    s_axis_tdata  = {c1[15:0], c0[15:0]};
    s_axis_tvalid = v;
    @(negedge aclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, 1'b0);
  endtask

  task automatic cfg(input bit ch, input bit pol, input int lvl, input int hys, input int hld);
    ch_flag  = ch;
    pol_flag = pol;
    lvl_data = lvl[15:0];
    hys_data = hys[15:0];
    hld_data = hld;
  endtask

  task automatic rearm();
    en_flag = 1'b0;
    idle(1);
    en_flag = 1'b1;
    idle(1);
  endtask

  initial begin : stimulus
    int n0;
    @(negedge aclk);
    // Reset with live input traffic: outputs must stay cleared.
    areset = 1'b1;
    beat(16'h1234, 16'h5678, 1'b1);
    beat(16'h1234, 16'h5678, 1'b1);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_trg", trg_flag, 0);
    check("rst_sts", sts_data, 0);
    areset = 1'b0;

    // Rising, ch0, lvl 100, hys 10, holdoff 0; ch1 parked above level.
    cfg(0, 0, 100, 10, 0);
    rearm();
    n0 = trig_ch0.size();
    beat(0, 200, 1'b1);
    beat(95, 200, 1'b1);
    beat(90, 200, 1'b1);
    beat(100, 200, 1'b1);
    idle(2);
    check("s1_count", trig_ch0.size() - n0, 1);
    if (trig_ch0.size() > n0) check("s1_value", trig_ch0[n0], 100);
    check("s1_sts", sts_data, 1);

    // Falling, ch1, lvl -50, hys 5, holdoff 3; two ramps 0 -> -60 -> 0.
    cfg(1, 1, -50, 5, 3);
    rearm();
    n0 = trig_ch1.size();
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v >= -60; v -= 5) beat(-100, v, 1'b1);
      for (int v = -55; v <= 0; v += 5) beat(-100, v, 1'b1);
    end
    idle(2);
    check("s2_count", trig_ch1.size() - n0, 2);
    if (trig_ch1.size() >= n0 + 2) begin
      check("s2_value0", trig_ch1[n0], -50);
      check("s2_value1", trig_ch1[n0 + 1], -50);
    end
    check("s2_sts", sts_data, 3);

    // Rising, holdoff 4, sawtooth crossing the level every two beats.
    cfg(0, 0, 0, 10, 4);
    rearm();
    n0 = trig_idx.size();
    for (int i = 0; i < 20; i++) beat((i % 2) ? 20 : -20, 0, 1'b1);
    idle(2);
    check("s3_count", trig_idx.size() - n0, 3);
    for (int k = n0 + 1; k < trig_idx.size(); k++)
      check("s3_spacing_ge5", (trig_idx[k] - trig_idx[k - 1]) >= 5, 1);
    check("s3_sts", sts_data, 6);

    // Gappy tvalid: invalid beats above level must not fire.
    cfg(0, 0, 100, 10, 0);
    rearm();
    n0 = trig_ch0.size();
    beat(0, 0, 1'b1);
    beat(200, 0, 1'b0);
    beat(50, 0, 1'b1);
    beat(200, 0, 1'b0);
    beat(150, 0, 1'b1);
    check("s4_latency_data", m_axis_tdata, 150);
    check("s4_trg_on_beat", trg_flag, 1);
    beat(0, 0, 1'b0);
    check("s4_trg_cleared", trg_flag, 0);
    check("s4_tvalid_low", m_axis_tvalid, 0);
    idle(1);
    check("s4_count", trig_ch0.size() - n0, 1);
    check("s4_sts", sts_data, 7);

    // Full-scale rising: lvl 32767, hys 65535 -> arm only at -32768.
    cfg(0, 0, 32767, 65535, 0);
    rearm();
    n0 = trig_ch0.size();
    beat(32767, 0, 1'b1);
    beat(-32767, 0, 1'b1);
    beat(32767, 0, 1'b1);
    beat(-32768, 0, 1'b1);
    beat(32766, 0, 1'b1);
    beat(32767, 0, 1'b1);
    idle(2);
    check("s5_count", trig_ch0.size() - n0, 1);
    if (trig_ch0.size() > n0) check("s5_value", trig_ch0[n0], 32767);
    check("s5_sts", sts_data, 8);

    // Full-scale falling: lvl -32768, hys 0.
    cfg(0, 1, -32768, 0, 0);
    rearm();
    n0 = trig_ch0.size();
    beat(32767, 0, 1'b1);
    beat(32767, 0, 1'b1);
    beat(-32768, 0, 1'b1);
    beat(-32768, 0, 1'b1);
    beat(-32768, 0, 1'b1);
    beat(-32768, 0, 1'b1);
    idle(2);
    check("s5b_count", trig_ch0.size() - n0, 2);
    check("s5b_sts", sts_data, 10);

    // en_flag dropped while armed: crossing is ignored, a fresh arm beat is needed.
    cfg(0, 0, 100, 10, 0);
    rearm();
    n0 = trig_ch0.size();
    beat(0, 0, 1'b1);
    en_flag = 1'b0;
    beat(150, 0, 1'b1);
    check("s6_no_trg_disabled", trg_flag, 0);
    en_flag = 1'b1;
    beat(150, 0, 1'b1);
    beat(150, 0, 1'b1);
    check("s6_no_trg_unarmed", trg_flag, 0);
    beat(0, 0, 1'b1);
    beat(150, 0, 1'b1);
    check("s6_trg_after_rearm", trg_flag, 1);
    idle(1);
    check("s6_count", trig_ch0.size() - n0, 1);
    check("s6_sts", sts_data, 11);

    // Reset during holdoff clears the count; a new arm beat is needed afterwards.
    cfg(0, 0, 100, 10, 5);
    rearm();
    beat(0, 0, 1'b1);
    beat(150, 0, 1'b1);
    check("s7_trg", trg_flag, 1);
    areset = 1'b1;
    beat(150, 0, 1'b1);
    beat(0, 0, 1'b1);
    check("s7_rst_sts", sts_data, 0);
    check("s7_rst_trg", trg_flag, 0);
    areset = 1'b0;
    beat(150, 0, 1'b1);
    beat(150, 0, 1'b1);
    check("s7_no_trg_unarmed", trg_flag, 0);
    beat(0, 0, 1'b1);
    beat(150, 0, 1'b1);
    check("s7_trg_after_rearm", trg_flag, 1);
    idle(1);
    check("s7_sts", sts_data, 1);

    // Reset on the firing beat discards the pending trigger.
    cfg(0, 0, 100, 10, 0);
    rearm();
    beat(0, 0, 1'b1);
    areset = 1'b1;
    beat(150, 0, 1'b1);
    check("s8_pending_discarded", trg_flag, 0);
    check("s8_sts", sts_data, 0);
    areset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
